// File: rtl/spi_host_core_if.sv
// User-side byte stream bundle for spi_host_core.
// Signals: cs_req/data/valid in, ready/miso data/stb/busy out.
interface spi_host_core_if;
  logic       usr_cs_req;
  logic [7:0] usr_mosi_data;
  logic       usr_mosi_valid;
  logic       usr_mosi_ready;
  logic [7:0] usr_miso_data;
  logic       usr_miso_stb;
  logic       busy;

  modport master (
    output usr_cs_req, usr_mosi_data, usr_mosi_valid,
    input  usr_mosi_ready, usr_miso_data, usr_miso_stb, busy
  );

  modport slave (
    input  usr_cs_req, usr_mosi_data, usr_mosi_valid,
    output usr_mosi_ready, usr_miso_data, usr_miso_stb, busy
  );
endinterface

// File: rtl/spi_host_core.sv
// SPI mode-0 host, one byte per handshake, MSB first.
// Ports: clk, rst_n, usr (slave), spi_mosi/miso/clk/cs_n.
// Optional macro SPI_HOST_CS_GAP_EN: enforce CS_GAP high time.
module spi_host_core #(
  parameter int unsigned DIV    = 2,
  parameter int unsigned CS_GAP = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_host_core_if.slave usr,
  output logic           spi_mosi,
  input  logic           spi_miso,
  output logic           spi_clk,
  output logic           spi_cs_n
);

`ifdef SPI_HOST_CS_GAP_EN
  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_ACTIVE, S_HOLD, S_GAP
  } state_e;
  localparam logic [7:0] GAP_M1 = 8'(CS_GAP - 1);
  logic [7:0] gap_q, gap_d;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_ACTIVE, S_HOLD
  } state_e;
`endif

  localparam logic [7:0] DIV_M1 = 8'(DIV - 1);
  // accept cycle already counts as the first low cycle
  localparam logic [7:0] DIV_M2 =
    (DIV > 1) ? 8'(DIV - 2) : 8'd0;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] half_q, half_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] rdat_q, rdat_d;
  logic       sck_q, sck_d;
  logic       csn_q, csn_d;
  logic       stb_q, stb_d;
  logic       ready;
  logic       accept;
  logic       close;

  assign ready = usr.usr_cs_req &&
    (state_q == S_IDLE || state_q == S_ACTIVE);
  assign accept = ready && usr.usr_mosi_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      half_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdat_q  <= '0;
      sck_q   <= 1'b0;
      csn_q   <= 1'b1;
      stb_q   <= 1'b0;
`ifdef SPI_HOST_CS_GAP_EN
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdat_q  <= rdat_d;
      sck_q   <= sck_d;
      csn_q   <= csn_d;
      stb_q   <= stb_d;
`ifdef SPI_HOST_CS_GAP_EN
      gap_q   <= gap_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdat_d  = rdat_q;
    sck_d   = sck_q;
    csn_d   = csn_q;
    stb_d   = 1'b0;
    close   = 1'b0;
`ifdef SPI_HOST_CS_GAP_EN
    gap_d   = gap_q;
`endif
    unique case (state_q)
      S_IDLE, S_ACTIVE: begin
        if (accept) begin
          tx_d    = usr.usr_mosi_data;
          csn_d   = 1'b0;
          state_d = S_SHIFT;
          half_d  = 4'd0;
          cnt_d   = DIV_M2;
          if (DIV == 1) begin
            // half-period 0 is the accept cycle alone
            sck_d  = 1'b1;
            half_d = 4'd1;
            rx_d   = {rx_q[6:0], spi_miso};
          end
        end else if (state_q == S_ACTIVE &&
                     !usr.usr_cs_req) begin
          if (DIV == 1) close = 1'b1;
          else begin
            state_d = S_HOLD;
            cnt_d   = DIV_M2;
          end
        end
      end
      S_SHIFT: begin
        if (cnt_q == 8'd0) begin
          cnt_d  = DIV_M1;
          half_d = half_q + 4'd1;
          if (!half_q[0]) begin
            sck_d = 1'b1;
            rx_d  = {rx_q[6:0], spi_miso};
          end else begin
            sck_d = 1'b0;
            if (half_q == 4'd15) begin
              state_d = S_ACTIVE;
              stb_d   = 1'b1;
              rdat_d  = rx_q;
            end else begin
              tx_d = {tx_q[6:0], 1'b0};
            end
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == 8'd0) close = 1'b1;
        else cnt_d = cnt_q - 8'd1;
      end
`ifdef SPI_HOST_CS_GAP_EN
      S_GAP: begin
        if (gap_q == 8'd0) state_d = S_IDLE;
        else gap_d = gap_q - 8'd1;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (close) begin
      csn_d = 1'b1;
`ifdef SPI_HOST_CS_GAP_EN
      state_d = S_GAP;
      gap_d   = GAP_M1;
`else
      state_d = S_IDLE;
`endif
    end
  end

  assign spi_mosi = !csn_q && tx_q[7];
  assign spi_clk  = sck_q;
  assign spi_cs_n = csn_q;

  assign usr.usr_mosi_ready = ready;
  assign usr.usr_miso_data  = rdat_q;
  assign usr.usr_miso_stb   = stb_q;
  assign usr.busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_host_core.sv
// Self-checking bench for spi_host_core (DIV=2, CS_GAP=4).
// Random bytes against a transaction-level SPI model.
module tb_spi_host_core;
  localparam int DIV    = 2;
  localparam int CS_GAP = 4;
  localparam int LAT    = 16 * DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic spi_mosi, spi_miso, spi_clk, spi_cs_n;
  spi_host_core_if usr();

  spi_host_core #(.DIV(DIV), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .usr(usr),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_clk(spi_clk), .spi_cs_n(spi_cs_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         acc_c[$], stb_c[$], rise_c[$];
  int         csf_c[$], csr_c[$];
  logic [7:0] stb_d[$];
  logic       mosi_b[$];
  logic [7:0] dev_q[$];
  int         dev_ptr = 0, dev_bit = 0;
  logic [7:0] dev_b;
  logic       dev_miso = 1'b0;
  logic       loop = 1'b0;
  logic       sck_p = 1'b0, cs_p = 1'b1;

  assign spi_miso = loop ? spi_mosi : dev_miso;

  // bus monitor plus mode-0 device that shifts on SCK low
  always @(negedge clk) begin
    if (usr.usr_mosi_valid && usr.usr_mosi_ready)
      acc_c.push_back(cyc);
    if (usr.usr_miso_stb) begin
      stb_c.push_back(cyc);
      stb_d.push_back(usr.usr_miso_data);
    end
    if (spi_clk && !sck_p) begin
      rise_c.push_back(cyc);
      mosi_b.push_back(spi_mosi);
      dev_bit++;
      if (dev_bit == 8) begin
        dev_bit = 0;
        dev_ptr++;
      end
    end
    if (!spi_cs_n && cs_p) csf_c.push_back(cyc);
    if (spi_cs_n && !cs_p) csr_c.push_back(cyc);
    if (!spi_clk) begin
      dev_b = (dev_ptr < dev_q.size()) ?
        dev_q[dev_ptr] : 8'h00;
      dev_miso = dev_b[7 - dev_bit];
    end
    sck_p = spi_clk;
    cs_p  = spi_cs_n;
  end

  task automatic clear_mon();
    acc_c.delete(); stb_c.delete(); rise_c.delete();
    csf_c.delete(); csr_c.delete(); stb_d.delete();
    mosi_b.delete(); dev_q.delete();
    dev_ptr = 0;
    dev_bit = 0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // present a byte and hold valid until it is taken
  task automatic start_byte(input logic [7:0] d);
    int n;
    n = 0;
    usr.usr_mosi_data  = d;
    usr.usr_mosi_valid = 1'b1;
    @(negedge clk);
    while (!usr.usr_mosi_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    usr.usr_mosi_valid = 1'b0;
    usr.usr_mosi_data  = 8'($urandom);
  endtask

  function automatic logic [7:0] mosi_byte(input int k);
    logic [7:0] v;
    v = 8'h00;
    for (int j = 0; j < 8; j++)
      if (k * 8 + j < mosi_b.size())
        v = {v[6:0], mosi_b[k * 8 + j]};
    return v;
  endfunction

  task automatic test_reset();
    usr.usr_cs_req = 1'b0;
    usr.usr_mosi_valid = 1'b0;
    usr.usr_mosi_data = 8'h00;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({spi_cs_n, spi_clk, spi_mosi} !== 3'b100) begin
      failures++;
      $display("FAIL rst_pins got=%b exp=100",
        {spi_cs_n, spi_clk, spi_mosi});
    end
    checks++;
    if ({usr.usr_miso_stb, usr.busy,
         usr.usr_miso_data} !== 10'h000) begin
      failures++;
      $display("FAIL rst_usr got=%h exp=000",
        {usr.usr_miso_stb, usr.busy, usr.usr_miso_data});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    usr.usr_cs_req = 1'b1;
    #1;
    checks++;
    if (usr.usr_mosi_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_ready got=%b exp=1",
        usr.usr_mosi_ready);
    end
    usr.usr_cs_req = 1'b0;
    wait_cyc(2);
  endtask

  task automatic test_loopback();
    int a;
    clear_mon();
    loop = 1'b1;
    usr.usr_cs_req = 1'b1;
    start_byte(8'hA5);
    usr.usr_cs_req = 1'b0;
    wait_cyc(LAT + 10);
    a = (acc_c.size() > 0) ? acc_c[0] : -1000;
    checks++;
    if (csf_c.size() != 1 || csf_c[0] != a + 1) begin
      failures++;
      $display("FAIL lb_csfall n=%0d acc=%0d",
        csf_c.size(), a);
    end
    checks++;
    if (rise_c.size() != 8) begin
      failures++;
      $display("FAIL lb_rises got=%0d exp=8", rise_c.size());
    end
    checks++;
    if (stb_c.size() != 1 || stb_c[0] != a + LAT) begin
      failures++;
      $display("FAIL lb_stb n=%0d acc=%0d exp_lat=%0d",
        stb_c.size(), a, LAT);
    end
    checks++;
    if (stb_d.size() != 1 || stb_d[0] !== 8'hA5) begin
      failures++;
      $display("FAIL lb_data n=%0d exp=a5", stb_d.size());
    end
    checks++;
    if (mosi_byte(0) !== 8'hA5) begin
      failures++;
      $display("FAIL lb_mosi got=%h exp=a5", mosi_byte(0));
    end
    loop = 1'b0;
  endtask

  task automatic test_device();
    clear_mon();
    dev_q.push_back(8'h3C);
    usr.usr_cs_req = 1'b1;
    start_byte(8'hFF);
    usr.usr_cs_req = 1'b0;
    wait_cyc(LAT + 10);
    checks++;
    if (stb_d.size() != 1 || stb_d[0] !== 8'h3C) begin
      failures++;
      $display("FAIL dev_data n=%0d exp=3c", stb_d.size());
    end
    checks++;
    if (mosi_b.size() != 8 || mosi_byte(0) !== 8'hFF) begin
      failures++;
      $display("FAIL dev_mosi got=%h n=%0d exp=ff",
        mosi_byte(0), mosi_b.size());
    end
  endtask

  task automatic test_random();
    logic [7:0] tx, rx;
    int a;
    for (int i = 0; i < 6; i++) begin
      clear_mon();
      tx = 8'($urandom);
      rx = 8'($urandom);
      dev_q.push_back(rx);
      usr.usr_cs_req = 1'b1;
      start_byte(tx);
      usr.usr_cs_req = 1'b0;
      wait_cyc(LAT + 10);
      a = (acc_c.size() > 0) ? acc_c[0] : -1000;
      checks++;
      if (stb_c.size() != 1 || stb_c[0] != a + LAT) begin
        failures++;
        $display("FAIL rnd%0d_stb n=%0d acc=%0d",
          i, stb_c.size(), a);
      end
      checks++;
      if (stb_d.size() != 1 || stb_d[0] !== rx) begin
        failures++;
        $display("FAIL rnd%0d_miso n=%0d exp=%h",
          i, stb_d.size(), rx);
      end
      checks++;
      if (mosi_byte(0) !== tx) begin
        failures++;
        $display("FAIL rnd%0d_mosi got=%h exp=%h",
          i, mosi_byte(0), tx);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n, bad;
    clear_mon();
    loop = 1'b1;
    usr.usr_cs_req = 1'b1;
    usr.usr_mosi_data = 8'hC1;
    usr.usr_mosi_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!usr.usr_mosi_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    usr.usr_mosi_data = 8'hC2;
    start_byte(8'hC2);
    usr.usr_cs_req = 1'b0;
    wait_cyc(LAT + 10);
    checks++;
    if (stb_c.size() != 2 ||
        stb_c[1] - stb_c[0] != LAT) begin
      failures++;
      $display("FAIL b2b_stb n=%0d exp_gap=%0d",
        stb_c.size(), LAT);
    end
    checks++;
    if (stb_d.size() != 2 || stb_d[0] !== 8'hC1 ||
        stb_d[1] !== 8'hC2) begin
      failures++;
      $display("FAIL b2b_data n=%0d exp=c1,c2",
        stb_d.size());
    end
    bad = 0;
    for (int i = 1; i < rise_c.size(); i++)
      if (rise_c[i] - rise_c[i - 1] != 2 * DIV) bad++;
    checks++;
    if (rise_c.size() != 16 || bad != 0) begin
      failures++;
      $display("FAIL b2b_sck rises=%0d bad_gaps=%0d",
        rise_c.size(), bad);
    end
    checks++;
    if (csf_c.size() != 1 || csr_c.size() != 1 ||
        stb_c.size() != 2 || csr_c[0] <= stb_c[1]) begin
      failures++;
      $display("FAIL b2b_cs falls=%0d rises=%0d",
        csf_c.size(), csr_c.size());
    end
    checks++;
    if (mosi_byte(0) !== 8'hC1 ||
        mosi_byte(1) !== 8'hC2) begin
      failures++;
      $display("FAIL b2b_mosi got=%h,%h exp=c1,c2",
        mosi_byte(0), mosi_byte(1));
    end
    loop = 1'b0;
  endtask

  task automatic test_cs_drop();
    int n;
    clear_mon();
    dev_q.push_back(8'h96);
    usr.usr_cs_req = 1'b1;
    start_byte(8'h69);
    n = 0;
    while (rise_c.size() < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    usr.usr_cs_req = 1'b0;
    wait_cyc(LAT + 10);
    checks++;
    if (stb_c.size() != 1 || stb_d[0] !== 8'h96 ||
        rise_c.size() != 8) begin
      failures++;
      $display("FAIL drop_byte stb=%0d rises=%0d",
        stb_c.size(), rise_c.size());
    end
    checks++;
    if (csr_c.size() != 1 || stb_c.size() != 1 ||
        csr_c[0] != stb_c[0] + DIV) begin
      failures++;
      $display("FAIL drop_csrise n=%0d exp_after_fall=%0d",
        csr_c.size(), DIV);
    end
    checks++;
    if (usr.busy !== 1'b0) begin
      failures++;
      $display("FAIL drop_busy got=%b exp=0", usr.busy);
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    loop = 1'b1;
    usr.usr_cs_req = 1'b1;
    start_byte(8'h5A);
    wait_cyc(10);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({spi_cs_n, spi_clk, spi_mosi,
         usr.usr_miso_stb, usr.busy} !== 5'b10000) begin
      failures++;
      $display("FAIL rmid_pins got=%b exp=10000",
        {spi_cs_n, spi_clk, spi_mosi,
         usr.usr_miso_stb, usr.busy});
    end
    checks++;
    if (usr.usr_miso_data !== 8'h00) begin
      failures++;
      $display("FAIL rmid_data got=%h exp=00",
        usr.usr_miso_data);
    end
    wait_cyc(3);
    rst_n = 1'b1;
    #1;
    checks++;
    if (usr.usr_mosi_ready !== 1'b1 || usr.busy !== 1'b0) begin
      failures++;
      $display("FAIL rmid_ready got=%b busy=%b exp=1,0",
        usr.usr_mosi_ready, usr.busy);
    end
    usr.usr_cs_req = 1'b0;
    wait_cyc(LAT + 10);
    checks++;
    if (stb_c.size() != 0) begin
      failures++;
      $display("FAIL rmid_stb got=%0d exp=0", stb_c.size());
    end
    loop = 1'b0;
  endtask

  task automatic test_gap();
    int n, r, exp_low;
`ifdef SPI_HOST_CS_GAP_EN
    exp_low = CS_GAP;
`else
    exp_low = 0;
`endif
    clear_mon();
    loop = 1'b1;
    usr.usr_cs_req = 1'b1;
    start_byte(8'h81);
    usr.usr_cs_req = 1'b0;
    n = 0;
    @(negedge clk);
    while (!spi_cs_n && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!spi_cs_n || n < 4) begin
      failures++;
      $display("FAIL gap_csrise_timeout n=%0d", n);
    end
    r = cyc;
    usr.usr_cs_req = 1'b1;
    #1;
    n = 0;
    while (!usr.usr_mosi_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != exp_low) begin
      failures++;
      $display("FAIL gap_ready_low got=%0d exp=%0d",
        n, exp_low);
    end
    start_byte(8'h18);
    usr.usr_cs_req = 1'b0;
    wait_cyc(LAT + 10);
    checks++;
    if (csf_c.size() != 2 ||
        csf_c[1] - r < exp_low + 1) begin
      failures++;
      $display("FAIL gap_cs_high n=%0d min=%0d",
        csf_c.size(), exp_low + 1);
    end
    loop = 1'b0;
  endtask

  initial begin
    usr.usr_cs_req = 1'b0;
    usr.usr_mosi_valid = 1'b0;
    usr.usr_mosi_data = 8'h00;
    test_reset();
    test_loopback();
    test_device();
    test_random();
    test_back_to_back();
    test_cs_drop();
    test_reset_mid();
    test_gap();
    $display("TB_RESULT checks=%0d failures=%0d",
      checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_host_core.md
SPI_HOST_CORE -- requirements
Module: spi_host_core

Interface
REQ-001 Parameter DIV, default 2: SCK half-period in clk cycles; legal range 1..255.
REQ-002 Parameter CS_GAP, default 4: minimum spi_cs_n high time in clk cycles; used only when SPI_HOST_CS_GAP_EN is defined.
REQ-003 clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 spi_mosi  output  1  serial data to device.
REQ-006 spi_miso  input  1  serial data from device.
REQ-007 spi_clk  output  1  SCK, SPI mode 0 (idle low).
REQ-008 spi_cs_n  output  1  chip select, active-low.
REQ-009 usr_cs_req  input  1  high = hold chip select asserted across bytes.
REQ-010 usr_mosi_data  input  8  byte to transmit.
REQ-011 usr_mosi_valid  input  1  usr_mosi_data is valid.
REQ-012 usr_mosi_ready  output  1  byte accepted when valid and ready are both high.
REQ-013 usr_miso_data  output  8  last received byte; held until the next strobe.
REQ-014 usr_miso_stb  output  1  one-cycle pulse: usr_miso_data is updated.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 States SHALL be IDLE, SHIFT, ACTIVE, HOLD and GAP; GAP exists only with SPI_HOST_CS_GAP_EN.
REQ-017 usr_mosi_ready SHALL equal usr_cs_req AND (state is IDLE or ACTIVE).
REQ-018 On accept: load the shift register, drive spi_cs_n low and spi_mosi to bit 7 from the next cycle, and enter SHIFT.
REQ-019 SHIFT SHALL run 16 half-periods of DIV cycles each, starting with the SCK-low phase; MSB is sent first.
REQ-020 spi_miso SHALL be sampled at each SCK rising edge.
REQ-021 spi_mosi SHALL advance to the next bit at each SCK falling edge except the last.
REQ-022 usr_miso_stb SHALL assert exactly 16*DIV cycles after the accept cycle, coincident with the final SCK falling edge; the state becomes ACTIVE.
REQ-023 In ACTIVE with usr_cs_req high, ready is high in the strobe cycle; a byte accepted then gives continuous SCK with no extra low time.
REQ-024 ACTIVE with usr_cs_req low: enter HOLD, keep spi_cs_n low for DIV cycles, then drive spi_cs_n high and go to IDLE (or GAP).
REQ-025 If usr_cs_req falls during SHIFT, the byte SHALL complete normally, then REQ-024 applies.
REQ-026 Valid asserted while ready is low SHALL be ignored; usr_mosi_data is sampled only in the accept cycle.
REQ-027 spi_mosi SHALL be 0 whenever spi_cs_n is high.
REQ-028 DIV counter width SHALL be 8 bits, reloading at 0 with no wrap beyond DIV-1.

Reset
REQ-029 rst_n low SHALL immediately force: spi_cs_n=1, spi_clk=0, spi_mosi=0, usr_miso_stb=0, usr_miso_data=8'h00, busy=0, state=IDLE.
REQ-030 Reset mid-byte SHALL abort the transfer with no strobe; the partial byte is discarded.
REQ-031 After rst_n rises, the first accept SHALL be possible in the first clock edge.

Configuration
REQ-032 Macro SPI_HOST_CS_GAP_EN defined: after spi_cs_n rises, the block SHALL stay in GAP for CS_GAP cycles with ready low, then enter IDLE.
REQ-033 Macro undefined: HOLD goes directly to IDLE; the GAP state and its counter SHALL not be built.

Verification
REQ-034 DIV=2, cs_req=1, send 8'hA5 with miso looped to mosi -> cs_n falls the cycle after accept, 8 SCK rises, strobe 32 cycles after accept, usr_miso_data=8'hA5.
REQ-035 Back-to-back 8'hC1 then 8'hC2 with valid held high -> 16 uninterrupted SCK periods, two strobes 32 cycles apart, cs_n low throughout.
REQ-036 cs_req dropped at bit 3 -> byte completes, cs_n rises 2 cycles after the final SCK fall, busy drops.
REQ-037 Device drives 8'h3C while host sends 8'hFF -> usr_miso_data=8'h3C; spi_mosi is 1 for all 8 bits.
REQ-038 rst_n pulsed low mid-byte -> outputs reach reset values with no clock edge, no strobe; after release, cs_req=1 gives ready=1.
REQ-039 SPI_HOST_CS_GAP_EN defined, CS_GAP=4, cs_req re-raised right after cs_n rises -> ready low for 4 cycles, cs_n high for at least 4 cycles; without the macro, ready is high the cycle after IDLE.
